// File: rtl/freeze_hold_pkg.sv
// Shared constants and the hold-select helper for the freeze_hold sample-and-hold stage.
// The s control is active-low: a registered 1 means tracking and a registered 0 means frozen.
package freeze_hold_pkg;

    localparam logic S_TRACK = 1'b1;

    // Next value of the held word: follow the sample while tracking, otherwise keep it.
    function automatic logic [63:0] hold_sel(input logic track, input logic [63:0] sample,
                                             input logic [63:0] held);
        return track ? sample : held;
    endfunction

endpackage

// File: rtl/freeze_hold_sync_reg.sv
// Generic register with load enable and a synchronous, active-high reset to a parameterised value.
module freeze_hold_sync_reg #(
    parameter int                 width   = 8,
    parameter logic [width-1:0]   rst_val = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/freeze_hold.sv
// Two-stage sample-and-hold: inter samples in every cycle, out follows inter unless s was low.
// The freeze acts from the registered s, so a falling s lets one more sample through.
module freeze_hold
    import freeze_hold_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s,
    input  logic [width-1:0] in,
    output logic [width-1:0] inter,
    output logic [width-1:0] out
);

    logic             s_q;
    logic [63:0]      sel_wide;
    logic [width-1:0] out_nxt;

    // Stage p0: register the control and the live input word.
    freeze_hold_sync_reg #(.width(1), .rst_val(S_TRACK)) u_s_q (
        .clk (clk),
        .rst (reset_n),
        .en  (1'b1),
        .d   (s),
        .q   (s_q)
    );

    freeze_hold_sync_reg #(.width(width), .rst_val('0)) u_inter (
        .clk (clk),
        .rst (reset_n),
        .en  (1'b1),
        .d   (in),
        .q   (inter)
    );

    // Stage p1: hold mux, track the sample while s_q is high, otherwise recirculate.
    always_comb begin
        sel_wide = hold_sel(s_q == S_TRACK, 64'(inter), 64'(out));
        out_nxt  = sel_wide[width-1:0];
    end

    freeze_hold_sync_reg #(.width(width), .rst_val('0)) u_out (
        .clk (clk),
        .rst (reset_n),
        .en  (1'b1),
        .d   (out_nxt),
        .q   (out)
    );

endmodule

// File: tb/tb_freeze_hold.sv
// Directed bench for freeze_hold: reset, freeze/release, reset while frozen and a one-cycle freeze pulse.
module tb_freeze_hold;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s;
    logic [7:0] in;
    logic [7:0] inter;
    logic [7:0] out;

    int total = 0;
    int bad   = 0;

    freeze_hold #(.width(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s       (s),
        .in      (in),
        .inter   (inter),
        .out     (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", tag, act, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] ramp_exp [8];
    logic [7:0] prev_in;

    initial begin
        ramp_exp = '{8'h10, 8'h20, 8'h21, 8'h21, 8'h23, 8'h24, 8'h25, 8'h26};

        // Reset with a live input present.
        reset_n = 1'b1; s = 1'b1; in = 8'hFF;
        step(2);
        check("rst_inter", inter, 8'h00);
        check("rst_out", out, 8'h00);
        reset_n = 1'b0;
        step(1);
        check("rel1_inter", inter, 8'hFF);
        check("rel1_out", out, 8'h00);
        step(1);
        check("rel2_inter", inter, 8'hFF);
        check("rel2_out", out, 8'hFF);

        // Freeze press, then the input changes underneath the frozen output.
        s = 1'b0;
        step(2);
        check("frz_out", out, 8'hFF);
        in = 8'h00;
        step(2);
        check("frz_inter", inter, 8'h00);
        check("frz_out2", out, 8'hFF);
        for (int i = 0; i < 10; i++) begin
            prev_in = in;
            in = (i % 2 == 0) ? 8'h5A : 8'h00;
            step(1);
            check("hold_inter", inter, in);
            check("hold_out", out, 8'hFF);
        end

        // Release: tracking resumes after two edges.
        s = 1'b1; in = 8'h00;
        step(1);
        check("rls1_out", out, 8'hFF);
        step(1);
        check("rls2_out", out, 8'h00);
        in = 8'h3C;
        step(1);
        check("lat1_out", out, 8'h00);
        step(1);
        check("lat2_out", out, 8'h3C);

        // Reset while frozen clears out; tracking resumes afterwards.
        in = 8'hFF;
        step(2);
        check("pre_frz_out", out, 8'hFF);
        s = 1'b0;
        step(2);
        check("frz_b_out", out, 8'hFF);
        reset_n = 1'b1;
        step(1);
        check("rstf_out", out, 8'h00);
        check("rstf_inter", inter, 8'h00);
        reset_n = 1'b0; s = 1'b1; in = 8'hA5;
        step(1);
        check("rstf_rel1", out, 8'h00);
        step(1);
        check("rstf_rel2", out, 8'hA5);

        // Reset released with s low: out stays 0 until s goes high.
        reset_n = 1'b1; s = 1'b0;
        step(1);
        reset_n = 1'b0; in = 8'h77;
        step(1);
        check("rlo1_out", out, 8'h00);
        check("rlo1_inter", inter, 8'h77);
        step(2);
        check("rlo2_out", out, 8'h00);
        s = 1'b1;
        step(1);
        check("rlo3_out", out, 8'h00);
        step(1);
        check("rlo4_out", out, 8'h77);

        // One-cycle freeze pulse during a ramp: one value repeats once.
        in = 8'h10;
        step(1);
        for (int k = 0; k < 8; k++) begin
            in = 8'h20 + 8'(k);
            s  = (k == 2) ? 1'b0 : 1'b1;
            step(1);
            check($sformatf("ramp%0d", k), out, ramp_exp[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
